// File: rtl/disp_scan32_pkg.sv
// rtl/disp_scan32_pkg.sv - shared display constants and hex glyph table
package disp_scan32_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low a..g glyphs, bit0 = a; entry 0 sits in the least significant slot
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/disp_scan32_if.sv
// rtl/disp_scan32_if.sv - display word inputs and scanned anode/segment outputs
interface disp_scan32_if;

  logic [31:0] data;
  logic [7:0]  point;
  logic [7:0]  blink;
  logic        disp_en;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic        frame_start;

  modport master (
    output data, point, blink, disp_en,
    input  AN, SEG, frame_start
  );

  modport slave (
    input  data, point, blink, disp_en,
    output AN, SEG, frame_start
  );

endinterface

// File: rtl/disp_scan32_hex2seg7.sv
// rtl/disp_scan32_hex2seg7.sv - combinational nibble to active-low seven-segment glyph
module hex2seg7
  import disp_scan32_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/disp_scan32.sv
// rtl/disp_scan32.sv - eight-digit multiplexed seven-segment scanner with frame snapshot
module disp_scan32
  import disp_scan32_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic          clk,
  input  logic          rst,
  disp_scan32_if.slave  bus
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [2:0]         dig;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [31:0]        snap_data;
  logic [7:0]         snap_point;
  logic [7:0]         snap_blink;

  // A frame starts on the first cycle of digit 0; the load cycle already
  // drives the outputs from the incoming word so digit 0 never shows stale data.
  logic        load;
  logic [31:0] nxt_data;
  logic [7:0]  nxt_point;
  logic [7:0]  nxt_blink;
  logic [3:0]  cur_nibble;
  logic [6:0]  glyph;

  assign load       = (dig == 3'd0) && (div_cnt == '0);
  assign nxt_data   = load ? bus.data  : snap_data;
  assign nxt_point  = load ? bus.point : snap_point;
  assign nxt_blink  = load ? bus.blink : snap_blink;
  assign cur_nibble = nxt_data[{dig, 2'b00} +: 4];

  hex2seg7 u_hex2seg7 (
    .nibble (cur_nibble),
    .seg    (glyph)
  );

  // Scan divider and digit index advance together
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      dig     <= 3'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig     <= dig + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Free-running blink timebase, independent of scanning
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Snapshot registers hold one whole frame so mid-frame input changes cannot tear it
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_data       <= '0;
      snap_point      <= '0;
      snap_blink      <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      snap_data       <= nxt_data;
      snap_point      <= nxt_point;
      snap_blink      <= nxt_blink;
      bus.frame_start <= load;
    end
  end

  // Registered anode/segment drive, one cycle behind the digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.AN  <= AN_OFF;
      bus.SEG <= SEG_OFF;
    end else begin
      bus.AN <= bus.disp_en ? ~(8'b1 << dig) : AN_OFF;
      if (blink_phase && nxt_blink[dig]) begin
        bus.SEG <= SEG_OFF;
      end else begin
        bus.SEG <= {~nxt_point[dig], glyph};
      end
    end
  end

endmodule

// File: tb/tb_disp_scan32.sv
// tb/tb_disp_scan32.sv - directed self-checking bench for disp_scan32
module tb_disp_scan32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  disp_scan32_if bus ();

  disp_scan32 #(
    .SCAN_DIV  (4),
    .BLINK_DIV (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; n counts edges since reset release. Outputs after edge n show
  // digit ((n-1)/4)%8 with blink phase ((n-1)/64)%2; frames load at n = 1, 33, 65, ...
  task automatic tick_check(input logic [31:0] d, input logic [7:0] p,
                            input logic [7:0] b, input logic en);
    int i;
    int ph;
    logic [7:0] ea;
    logic [7:0] es;
    @(negedge clk);
    n++;
    i  = ((n - 1) / 4) % 8;
    ph = ((n - 1) / 64) % 2;
    ea = en ? ~(8'b1 << i) : 8'hFF;
    if (b[i] && ph == 1) es = 8'hFF;
    else                 es = {~p[i], glyph(d[i*4 +: 4])};
    chk($sformatf("AN n=%0d", n), {24'd0, bus.AN}, {24'd0, ea});
    chk($sformatf("SEG n=%0d", n), {24'd0, bus.SEG}, {24'd0, es});
    chk($sformatf("frame_start n=%0d", n), {31'd0, bus.frame_start},
        {31'd0, ((n - 1) % 32) == 0});
  endtask

  initial begin
    rst         = 1'b1;
    bus.data    = 32'h76543210;
    bus.point   = 8'h00;
    bus.blink   = 8'h00;
    bus.disp_en = 1'b1;

    // Reset held for three edges
    repeat (3) @(negedge clk);
    chk("reset AN", {24'd0, bus.AN}, 32'hFF);
    chk("reset SEG", {24'd0, bus.SEG}, 32'hFF);
    chk("reset frame_start", {31'd0, bus.frame_start}, 32'h0);
    rst = 1'b0;

    // Reset exit: digits 0..7 show glyphs 0..7
    for (int k = 0; k < 32; k++) tick_check(32'h76543210, 8'h00, 8'h00, 1'b1);

    // No tearing: change word at digit 3 of the 0x11111111 frame
    bus.data = 32'h11111111;
    for (int k = 0; k < 12; k++) tick_check(32'h11111111, 8'h00, 8'h00, 1'b1);
    bus.data = 32'h88888888;
    for (int k = 0; k < 20; k++) tick_check(32'h11111111, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++)  tick_check(32'h88888888, 8'h00, 8'h00, 1'b1);

    // Point and blink, requested mid-frame so they land on the next load (n=97)
    bus.data  = 32'h00000000;
    bus.point = 8'h01;
    bus.blink = 8'h02;
    for (int k = 0; k < 24; k++) tick_check(32'h88888888, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 61; k++) tick_check(32'h00000000, 8'h01, 8'h02, 1'b1);

    // Display off for 10 cycles spanning the frame_start at n=161
    bus.disp_en = 1'b0;
    for (int k = 0; k < 10; k++) tick_check(32'h00000000, 8'h01, 8'h02, 1'b0);
    bus.disp_en = 1'b1;
    for (int k = 0; k < 14; k++) tick_check(32'h00000000, 8'h01, 8'h02, 1'b1);

    // Mid-frame reset while the digit index is 5 (after n=181)
    chk("pre-reset n", n, 32'd181);
    bus.data  = 32'hFEDCBA98;
    bus.point = 8'h00;
    bus.blink = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset AN", {24'd0, bus.AN}, 32'hFF);
    chk("mid reset SEG", {24'd0, bus.SEG}, 32'hFF);
    chk("mid reset frame_start", {31'd0, bus.frame_start}, 32'h0);
    n = 0;
    for (int k = 0; k < 32; k++) tick_check(32'hFEDCBA98, 8'h00, 8'h00, 1'b1);

    // Random soak with occasional resets: never more than one anode low
    for (int k = 0; k < 10000; k++) begin
      bus.data    = $urandom;
      bus.point   = 8'($urandom);
      bus.blink   = 8'($urandom);
      bus.disp_en = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      checks++;
      assert ($countones(~bus.AN) <= 1) else begin
        errors++;
        $error("FAIL onehot cycle=%0d observed=%0h expected=at most one low bit", k, bus.AN);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan32.md
DISP_SCAN32 -- requirements
Module: disp_scan32

Interface
REQ-001 SHALL have parameter: SCAN_DIV, 100000, clock cycles each digit is held active (legal range 2 to 2^20).
REQ-002 SHALL have parameter: BLINK_DIV, 25000000, clock cycles per blink half-period (legal range 2 to 2^26).
REQ-003 SHALL have port: clk  input  1  system clock; the block uses one clock and all state changes on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: data  input  32  display word from the upstream 8:1 32-bit selector; nibble i feeds digit i.
REQ-006 SHALL have port: point  input  8  decimal-point request, one bit per digit, 1 = dp lit.
REQ-007 SHALL have port: blink  input  8  blink enable, one bit per digit.
REQ-008 SHALL have port: disp_en  input  1  1 = display on, 0 = all anodes off.
REQ-009 SHALL have port: AN  output  8  digit anodes, active-low, one-hot-low.
REQ-010 SHALL have port: SEG  output  8  segment cathodes, active-low, with bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g and bit7=dp.
REQ-011 SHALL have frame_start  output  1  one-cycle pulse on the cycle data/point/blink are sampled.

Function
REQ-012 SHALL contain a divider counter div_cnt that counts 0 to SCAN_DIV-1 and then wraps to 0.
REQ-013 SHALL contain a 3-bit digit index dig that increments by one (7 wraps to 0) on each cycle where div_cnt = SCAN_DIV-1.
REQ-014 SHALL load data, point and blink into snapshot registers on every cycle where dig = 0 and div_cnt = 0, and hold them unchanged at all other times, so a frame is never torn.
REQ-015 SHALL assert frame_start, registered, in the cycle after each snapshot load.
REQ-016 SHALL register AN and SEG from the current dig and snapshot values, giving exactly one cycle of latency from a dig change to the corresponding AN/SEG change.
REQ-017 SHALL, for digit i with disp_en = 1, drive AN[i] low and all other AN bits high.
REQ-018 SHALL drive SEG[6:0] as the hex glyph of snapshot nibble [4i+3:4i], with 0->0x40, 1->0x79, 8->0x00 and F->0x0E, and the standard a-g patterns for all 16 values.
REQ-019 SHALL drive SEG[7] low when the snapshot point[i] = 1.
REQ-020 SHALL contain a free-running blink counter that toggles blink_phase every BLINK_DIV cycles.
REQ-021 SHALL, when blink_phase = 1 and the snapshot blink[i] = 1, force SEG = 0xFF while AN still selects digit i.
REQ-022 SHALL, when disp_en = 0, drive AN = 0xFF from the next edge while counters, snapshot loading and frame_start continue running unchanged.
REQ-023 SHALL ignore changes to data, point and blink in the middle of a frame until the next snapshot load.
REQ-024 SHALL never drive more than one AN bit low in any cycle, including at dig wrap and at reset exit.

Reset
REQ-025 SHALL, on any edge with rst = 1, set div_cnt = 0, dig = 0, snapshot = 0, blink counter = 0, blink_phase = 0, AN = 0xFF, SEG = 0xFF and frame_start = 0.
REQ-026 SHALL perform a snapshot load on the first edge after rst deasserts (dig = 0, div_cnt = 0), with AN = 0xFE one edge later.
REQ-027 SHALL abandon the current frame when rst is asserted mid-frame, with no partial output surviving the reset.

Structure
REQ-028 SHALL place the 16-entry hex-to-segment table and the constants SEG_OFF = 0xFF and AN_OFF = 0xFF in a shared display package.
REQ-029 SHALL implement the glyph decode as a combinational sub-module hex2seg7, nibble in and 7 bits out, which is reusable elsewhere.
REQ-030 SHALL implement everything else (counters, snapshot registers, output registers) in disp_scan32 itself.

Verification (SCAN_DIV=4, BLINK_DIV=64)
REQ-031 SHALL verify reset exit: rst high 3 cycles then low with data=0x76543210 -> AN sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles, with SEG showing glyphs 0..7.
REQ-032 SHALL verify no tearing: data changes from 0x11111111 to 0x88888888 at mid-frame (dig=3) -> digits 3-7 still show 0xF9, and 0x80 appears only after the next frame_start.
REQ-033 SHALL verify point and blink: point=0x01 and blink=0x02 -> digit 0 shows SEG[7]=0, and digit 1 shows SEG=0xFF while blink_phase=1 and its glyph while blink_phase=0.
REQ-034 SHALL verify disp_en: disp_en=0 for 10 cycles -> AN=0xFF throughout, frame_start keeps its 32-cycle period, and scanning resumes in phase when disp_en=1.
REQ-035 SHALL verify mid-frame reset: rst pulsed 1 cycle while dig=5 -> AN=0xFF for the cycle after the reset edge, then a snapshot load and AN=0xFE.
REQ-036 SHALL verify the one-hot invariant: a random data/point/blink/disp_en soak of 10k cycles -> the at-most-one-AN-low assertion never fires.
